// File: rtl/rx_ctrl_if.sv
// Bundle between the UART receive control stage and its neighbours: the raw serial
// line in, and the bit-timing and sample signals out to the receive datapath.
interface rx_ctrl_if;
  logic       rx_line;
  logic       rx_en;
  logic [9:0] bit_cnto;
  logic       rx_bit;
  logic       rx_done;
  logic       frame_err;

  // master: the control stage; slave: the line source and datapath side
  modport master (input rx_line, output rx_en, bit_cnto, rx_bit, rx_done, frame_err);
  modport slave  (output rx_line, input rx_en, bit_cnto, rx_bit, rx_done, frame_err);
endinterface

// File: rtl/rx_ctrl.sv
// UART receive control: line synchroniser, start-bit qualification, mid-bit sampling
// and bit indexing for an 8N1 frame. Reports completed frames and bad stop bits.
module rx_ctrl #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic         clk,
  input  logic         rst,
  rx_ctrl_if.master    bus,
  output logic [2:0]   state_dbg
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4,
    BREAK = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             line_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             rx_en_q, rx_en_d;
  logic             rx_bit_q, rx_bit_d;
  logic             rx_done_q, rx_done_d;
  logic             frame_err_q, frame_err_d;

  assign line_s = sync2_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    rx_en_d     = rx_en_q;
    rx_bit_d    = rx_bit_q;
    rx_done_d   = 1'b0;
    frame_err_d = frame_err_q;
    case (state_q)
      IDLE: begin
        rx_en_d = 1'b0;
        cnt_d   = '0;
        if (!line_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          // A line back high at the half-bit point was a glitch, not a start bit
          if (!line_s) begin
            bit_cnt_d   = 4'd0;
            rx_bit_d    = 1'b0;
            rx_en_d     = 1'b1;
            frame_err_d = 1'b0;
            state_d     = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          rx_bit_d  = line_s;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          rx_bit_d  = line_s;
          bit_cnt_d = 4'd9;
          state_d   = DONE;
        end
      end
      DONE: begin
        cnt_d = '0;
        if (rx_bit_q) begin
          rx_done_d = 1'b1;
          state_d   = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: begin
        // Held-low line must return high before another start can be armed
        rx_en_d = 1'b0;
        cnt_d   = '0;
        if (line_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      bit_cnt_q   <= 4'd0;
      rx_en_q     <= 1'b0;
      rx_bit_q    <= 1'b1;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.rx_line;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_en_q     <= rx_en_d;
      rx_bit_q    <= rx_bit_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.rx_en     = rx_en_q;
  assign bus.bit_cnto  = {6'd0, bit_cnt_q};
  assign bus.rx_bit    = rx_bit_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
  assign state_dbg     = state_q;
endmodule

// File: doc/rx_ctrl.md
# rx_ctrl

Receive-side control stage of the UART, directly upstream of the receive datapath. It synchronises the asynchronous serial line, detects and qualifies the start bit, and generates the bit-timing sequence `rx_en` / `bit_cnto`. It also produces a mid-bit sampled line value (`rx_bit`) that the datapath shifts into `rx_data`. It reports each completed frame with `rx_done` and each bad stop bit with `frame_err`.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200); legal range 4..1023.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `rx_line`  in  1  asynchronous serial input; idle high; 8N1, LSB first.
- `rx_en`  out  1  datapath enable; high while a qualified frame is in progress.
- `bit_cnto`  out  10  bit index: 0 = start, 1..8 = D0..D7, 9 = stop; drives the datapath bit counter input.
- `rx_bit`  out  1  line value sampled at the current bit's mid-point; drives the datapath `rx_in`.
- `rx_done`  out  1  one-cycle pulse; frame complete with valid stop bit.
- `frame_err`  out  1  level; stop bit sampled low; cleared at the next start qualification.

## Operation
- Synchroniser: 2-flop chain on `rx_line`, both flops reset to 1; `line_s` = second flop. All decisions use `line_s` only.
- Baud counter: width ceil(log2(CLKS_PER_BIT)); cleared on every state transition.
- States:
  - IDLE: `rx_en`=0. If `line_s`=0 -> START.
  - START: count to floor(CLKS_PER_BIT/2)-1, then sample `line_s`.
    - Sample 0: `bit_cnto`<=0, `rx_bit`<=0, `rx_en`<=1, `frame_err`<=0 -> DATA.
    - Sample 1: glitch; `rx_en` stays 0, outputs unchanged -> IDLE.
  - DATA: every CLKS_PER_BIT cycles, `rx_bit`<=`line_s` and `bit_cnto`<=`bit_cnto`+1 in the same cycle. After the sample that sets `bit_cnto`=8 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, `rx_bit`<=`line_s`, `bit_cnto`<=9 -> DONE.
  - DONE (1 cycle): `rx_en` stays 1.
    - `rx_bit`=1: `rx_done`=1 -> IDLE.
    - `rx_bit`=0: `frame_err`<=1 -> BREAK.
  - BREAK: `rx_en`=0. Wait for `line_s`=1 -> IDLE. No re-arm on a held-low line.
- On return to IDLE or BREAK, `rx_en` falls; `bit_cnto` and `rx_bit` hold their last values (9 and the stop sample).
- `bit_cnto` upper bits [9:4] are always 0.

## Timing
- Reset values: `rx_en`=0, `bit_cnto`=0, `rx_bit`=1, `rx_done`=0, `frame_err`=0, state IDLE, sync flops 1, baud counter 0.
- `rst` low takes effect on the next edge from any state, including mid-frame. The frame is dropped and no `rx_done` is issued.
- Falling edge on `rx_line` to IDLE->START: 2 cycles of synchroniser latency plus 1 cycle.
- Start sample: floor(CLKS_PER_BIT/2) cycles after entering START. Each later sample follows the previous one by exactly CLKS_PER_BIT cycles.
- `bit_cnto`=k and `rx_bit`=bit k are stable together from mid-bit k to mid-bit k+1. Each value holds for exactly CLKS_PER_BIT cycles, except `bit_cnto`=9, which holds until the next start qualification.
- `rx_done` rises 1 cycle after the stop sample and lasts exactly 1 cycle. `rx_en` falls on the cycle after `rx_done`.
- Back-to-back frames: DONE is reached about half a bit into the stop bit, so a start edge at the nominal end of the stop bit is detected.
- `rx_line` changes during START/DATA/STOP outside sample cycles have no effect.

## Test plan
(CLKS_PER_BIT=16 unless stated.)
- Reset: hold `rst`=0 for 3 cycles with `rx_line`=0 -> all outputs at reset values and state IDLE; release with `rx_line`=1 -> outputs unchanged.
- Frame 0xA5, stop=1 -> `bit_cnto` steps 0..9 at 16-cycle intervals; `rx_bit` sequence 0,1,0,1,0,0,1,0,1,1; one `rx_done` pulse; `frame_err`=0; downstream datapath yields `rx_data`=0xA5.
- Glitch: `rx_line` low for 5 cycles, then high -> `rx_en` never asserts, no `rx_done`, state returns to IDLE.
- Frame 0x3C with stop=0, line held low 40 cycles, then high -> `frame_err`=1 and no `rx_done`; no new frame starts until the line returns high; a following valid frame 0x01 clears `frame_err` at its start sample and gives `rx_done`.
- Back-to-back 0x55 then 0xFF, no idle gap -> two `rx_done` pulses exactly 160 cycles apart; `rx_bit` streams match both bytes.
- Mid-frame reset: assert `rst`=0 when `bit_cnto`=4 -> next cycle `rx_en`=0, `bit_cnto`=0, `rx_bit`=1; no `rx_done`; a fresh frame 0x81 after release is received correctly.
